// File: rtl/decode_stage_r32i.sv
// RV32I decode stage: combinational decode into a registered output slot backed by a skid slot.
// Define DECODE_ILLEGAL_TRAP_EN to add out_illegal and block intake after an illegal opcode.
module decode_stage_r32i #(
    parameter int unsigned dataW    = 32,
    parameter int unsigned regAddrW = $clog2(dataW)
) (
    input  logic                clk,
    input  logic                nReset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [dataW-1:0]    in_ins,
    input  logic [dataW-1:0]    in_pc,
    input  logic                flush,
    input  logic                ex_load_valid,
    input  logic [regAddrW-1:0] ex_load_rd,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [dataW-1:0]    out_pc,
    output logic [dataW-1:0]    out_imm,
    output logic [regAddrW-1:0] out_rs1,
    output logic [regAddrW-1:0] out_rs2,
    output logic [regAddrW-1:0] out_rd,
    output logic [5:0]          out_alucode,
`ifdef DECODE_ILLEGAL_TRAP_EN
    output logic                out_illegal,
`endif
    output logic [11:0]         out_ctrl
);

    localparam logic [6:0] OP_OPPI   = 7'b0010011;
    localparam logic [6:0] OP_OPPR   = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    // CPY sits above the 5-bit space reachable from {ins[25], ins[30], f3}.
    localparam logic [5:0] ALU_ADD = 6'b000000;
    localparam logic [5:0] ALU_CPY = 6'b100000;

    typedef struct packed {
        logic [dataW-1:0]    pc;
        logic [dataW-1:0]    imm;
        logic [regAddrW-1:0] rs1;
        logic [regAddrW-1:0] rs2;
        logic [regAddrW-1:0] rd;
        logic [5:0]          alucode;
        logic [11:0]         ctrl;
        logic                use_rs1;
        logic                use_rs2;
`ifdef DECODE_ILLEGAL_TRAP_EN
        logic                illegal;
`endif
    } bundle_t;

    logic [6:0]       w_opcode;
    logic [2:0]       w_f3;
    logic [dataW-1:0] w_imm_i;
    logic [dataW-1:0] w_imm_s;
    logic [dataW-1:0] w_imm_b;
    logic [dataW-1:0] w_imm_u;
    logic [dataW-1:0] w_imm_j;
    logic [8:0]       w_flags;
    logic             w_known;
    bundle_t          w_dec;

    assign w_opcode = in_ins[6:0];
    assign w_f3     = in_ins[14:12];
    assign w_imm_i  = {{(dataW-12){in_ins[31]}}, in_ins[31:20]};
    assign w_imm_s  = {{(dataW-12){in_ins[31]}}, in_ins[31:25], in_ins[11:7]};
    assign w_imm_b  = {{(dataW-12){in_ins[31]}}, in_ins[7], in_ins[30:25], in_ins[11:8], 1'b0};
    assign w_imm_u  = {{(dataW-31){in_ins[31]}}, in_ins[30:12], 12'b0};
    assign w_imm_j  = {{(dataW-20){in_ins[31]}}, in_ins[19:12], in_ins[20], in_ins[30:21], 1'b0};

    // w_flags: [8] RAMRegRead [7] RAMWrite [6] UsePC [5] UseImm [4] Absolute [3] Always
    //          [2] TestBranch [1] LinkAddrWrite [0] RegWrite
    always_comb begin
        w_flags       = 9'h000;
        w_known       = 1'b1;
        w_dec         = '0;
        w_dec.pc      = in_pc;
        w_dec.imm     = w_imm_i;
        w_dec.rs1     = in_ins[15 +: regAddrW];
        w_dec.rs2     = in_ins[20 +: regAddrW];
        w_dec.rd      = in_ins[7 +: regAddrW];
        w_dec.alucode = ALU_ADD;
        case (w_opcode)
            OP_OPPI: begin
                w_flags       = 9'h021;
                w_dec.use_rs1 = 1'b1;
                w_dec.alucode = (w_f3 == 3'd5) ? {2'b00, in_ins[30], w_f3} : {3'b000, w_f3};
            end
            OP_OPPR: begin
                w_flags       = 9'h001;
                w_dec.use_rs1 = 1'b1;
                w_dec.use_rs2 = 1'b1;
                w_dec.alucode = {1'b0, in_ins[25], in_ins[30], w_f3};
            end
            OP_LUI: begin
                w_flags       = 9'h021;
                w_dec.imm     = w_imm_u;
                w_dec.alucode = ALU_CPY;
            end
            OP_AUIPC: begin
                w_flags   = 9'h061;
                w_dec.imm = w_imm_u;
            end
            OP_JAL: begin
                w_flags       = 9'h02B;
                w_dec.imm     = w_imm_j;
                w_dec.alucode = ALU_CPY;
            end
            OP_JALR: begin
                w_flags       = 9'h03B;
                w_dec.use_rs1 = 1'b1;
            end
            OP_BRANCH: begin
                w_flags       = 9'h074;
                w_dec.imm     = w_imm_b;
                w_dec.use_rs1 = 1'b1;
                w_dec.use_rs2 = 1'b1;
            end
            OP_LOAD: begin
                w_flags       = 9'h121;
                w_dec.use_rs1 = 1'b1;
            end
            OP_STORE: begin
                w_flags       = 9'h1A0;
                w_dec.imm     = w_imm_s;
                w_dec.use_rs1 = 1'b1;
                w_dec.use_rs2 = 1'b1;
            end
            default: begin
                w_known       = 1'b0;
                w_dec.alucode = 6'b000000;
            end
        endcase
        w_dec.ctrl = w_known ? {w_f3, w_flags} : 12'h000;
`ifdef DECODE_ILLEGAL_TRAP_EN
        w_dec.illegal = ~w_known;
`endif
    end

    bundle_t r_out;
    bundle_t r_skid;
    logic    r_out_valid;
    logic    r_skid_valid;
    logic    r_in_ready;
    bundle_t w_out_d;
    bundle_t w_skid_d;
    logic    w_out_valid_d;
    logic    w_skid_valid_d;
    logic    w_in_ready_d;
    logic    w_hazard;
    logic    w_out_valid;
    logic    w_in_fire;
    logic    w_out_fire;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic    r_trap;
    logic    w_trap_d;
`endif

    // x0 never hazards; only the oldest held bundle is checked against the in-flight load.
    assign w_hazard = r_out_valid && ex_load_valid && (ex_load_rd != '0) &&
                      ((r_out.use_rs1 && (ex_load_rd == r_out.rs1)) ||
                       (r_out.use_rs2 && (ex_load_rd == r_out.rs2)));
    assign w_out_valid = r_out_valid & ~w_hazard;
    assign w_in_fire   = in_valid & r_in_ready;
    assign w_out_fire  = w_out_valid & out_ready;

    always_comb begin
        w_out_d        = r_out;
        w_skid_d       = r_skid;
        w_out_valid_d  = r_out_valid;
        w_skid_valid_d = r_skid_valid;
`ifdef DECODE_ILLEGAL_TRAP_EN
        w_trap_d       = r_trap;
`endif
        if (flush) begin
            w_out_valid_d  = 1'b0;
            w_skid_valid_d = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
            w_trap_d       = 1'b0;
`endif
        end else begin
            if (!r_out_valid || w_out_fire) begin
                if (r_skid_valid) begin
                    w_out_d        = r_skid;
                    w_out_valid_d  = 1'b1;
                    w_skid_valid_d = 1'b0;
                end else begin
                    w_out_d       = w_in_fire ? w_dec : r_out;
                    w_out_valid_d = w_in_fire;
                end
            end else if (w_in_fire) begin
                w_skid_d       = w_dec;
                w_skid_valid_d = 1'b1;
            end
`ifdef DECODE_ILLEGAL_TRAP_EN
            if (w_in_fire && w_dec.illegal) begin
                w_trap_d = 1'b1;
            end
`endif
        end
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    assign w_in_ready_d = ~w_skid_valid_d & ~w_trap_d;
`else
    assign w_in_ready_d = ~w_skid_valid_d;
`endif

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_out        <= '0;
            r_skid       <= '0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
`ifdef DECODE_ILLEGAL_TRAP_EN
            r_trap       <= 1'b0;
`endif
        end else begin
            r_out        <= w_out_d;
            r_skid       <= w_skid_d;
            r_out_valid  <= w_out_valid_d;
            r_skid_valid <= w_skid_valid_d;
            r_in_ready   <= w_in_ready_d;
`ifdef DECODE_ILLEGAL_TRAP_EN
            r_trap       <= w_trap_d;
`endif
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = w_out_valid;
    assign out_pc      = r_out.pc;
    assign out_imm     = r_out.imm;
    assign out_rs1     = r_out.rs1;
    assign out_rs2     = r_out.rs2;
    assign out_rd      = r_out.rd;
    assign out_alucode = r_out.alucode;
    assign out_ctrl    = r_out.ctrl;
`ifdef DECODE_ILLEGAL_TRAP_EN
    assign out_illegal = r_out.illegal;
`endif

endmodule

// File: doc/decode_stage_r32i.md
DECODE_STAGE_R32I -- requirements
Module: decode_stage_r32i

Interface
REQ-001 SHALL take parameter dataW, default 32: instruction, PC and immediate width.
REQ-002 SHALL take parameter regAddrW, default $clog2(dataW): register address width.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- nReset  in  1  asynchronous active-low reset.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  stage can accept; registered.
- in_ins  in  dataW  raw instruction.
- in_pc  in  dataW  instruction address.
- flush  in  1  discard all held and offered instructions.
- ex_load_valid  in  1  execute stage holds a LOAD.
- ex_load_rd  in  regAddrW  destination of that LOAD.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts the bundle.
- out_pc  out  dataW  PC of the bundle.
- out_imm  out  dataW  decoded immediate.
- out_rs1, out_rs2, out_rd  out  regAddrW each  ins[19:15], ins[24:20], ins[11:7].
- out_alucode  out  6  ALU operation code.
- out_ctrl  out  12  control word (REQ-007).
- out_illegal  out  1  illegal opcode flag; present only with the REQ-019 macro.

Function
REQ-005 SHALL decode the nine RV32I opcodes:
- OPPI 0010011: I-imm, UseImm, RegWrite; ALU = {1'b0, ins[30], f3} when f3=5, else {3'b0, f3}.
- OPPR 0110011: RegWrite; ALU = {ins[25], ins[30], f3}.
- LUI 0110111: U-imm, UseImm, RegWrite, ALU = CPY.
- AUIPC 0010111: U-imm, UseImm, UsePC, RegWrite, ALU = ADD.
- JAL 1101111: J-imm, AlwaysBranch, UseImm, LinkAddrWrite, RegWrite, ALU = CPY.
- JALR 1100111: I-imm, AlwaysBranch, AbsoluteBranch, UseImm, LinkAddrWrite, RegWrite, ALU = ADD.
- BRANCH 1100011: B-imm, TestBranch, AbsoluteBranch, UsePC, UseImm, ALU = ADD.
- LOAD 0000011: I-imm, RegWrite, UseImm, RAMRegRead, ALU = ADD.
- STORE 0100011: S-imm, UseImm, RAMWriteControl, RAMRegRead, ALU = ADD.
- ADD and CPY values SHALL come from the shared ALU code header.
REQ-006 SHALL sign-extend I, S, B and J immediates from ins[31]; U-imm SHALL be ins[31:12] followed by 12 zero bits.
REQ-007 SHALL pack out_ctrl as: [0] RegWrite, [1] LinkAddrWrite, [2] TestBranch, [3] AlwaysBranch, [4] AbsoluteBranch, [5] UseImm, [6] UsePC, [7] RAMWriteControl, [8] RAMRegRead, [11:9] BranchType (= f3).
REQ-008 SHALL leave out_ctrl = 0, out_alucode = 0 and out_imm = I-imm for an unknown opcode.
REQ-009 SHALL register the decoded bundle: an instruction accepted at edge N is visible with out_valid=1 after edge N; latency 1 cycle.
REQ-010 SHALL hold a 2-entry buffer (output register plus skid register), so in_ready depends only on state and full throughput is kept.
REQ-011 SHALL, when out_valid=1 and out_ready=0, keep every out_* field stable until a handshake completes.
REQ-012 SHALL define handshakes as in_valid & in_ready and out_valid & out_ready; an accepted instruction is never dropped or duplicated except by flush.
REQ-013 SHALL detect a load-use hazard when ex_load_valid=1, ex_load_rd != 0, and ex_load_rd matches a source read by the oldest held instruction:
- rs1 is read by OPPI, OPPR, JALR, BRANCH, LOAD, STORE.
- rs2 is read by OPPR, BRANCH, STORE.
- on a hazard, out_valid SHALL be forced to 0 for that cycle with the bundle retained.
REQ-014 SHALL treat register x0 as never hazarding.
REQ-015 SHALL, on flush=1 at an edge, empty both entries and ignore in_valid that cycle; flush takes priority over a simultaneous accept or output handshake.
REQ-016 SHALL, with the skid register full, drive in_ready=0; a simultaneous output handshake SHALL move skid to output and reassert in_ready next cycle.

Reset
REQ-017 SHALL, while nReset=0, asynchronously empty both entries, drive out_valid=0, in_ready=1, and zero all out_* fields.
REQ-018 SHALL, on reset assertion mid-handshake, discard held instructions; the first edge after release SHALL be able to accept.

Configuration
REQ-019 SHALL, with DECODE_ILLEGAL_TRAP_EN defined, flag an unknown opcode or ins[1:0] != 2'b11:
- out_illegal=1 and out_ctrl=0 for that bundle.
- the next accept stalls (in_ready=0) until flush.
- without the macro, the out_illegal port is absent and REQ-008 applies with no stall.

Verification
REQ-020 Reset then in_ins=0x00500093 (addi x1,x0,5) with out_ready=1 -> next cycle out_valid=1, out_imm=5, out_rd=1, out_ctrl[0]=1, out_ctrl[5]=1.
REQ-021 Back-to-back stream of 8 instructions, out_ready held 0 for 3 cycles -> in_ready falls after 2 accepts, all 8 emerge in order, none lost.
REQ-022 ex_load_valid=1, ex_load_rd=2, decode add x3,x2,x1 -> out_valid=0 that cycle, bundle emitted next cycle after ex_load_valid=0; same test with rd=0 -> no stall.
REQ-023 flush asserted with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1, the offered instruction discarded.
REQ-024 Beq with imm -8 (0xFE000CE3) -> out_imm=0xFFFFFFF8, out_ctrl[2]=1, out_ctrl[4]=1, out_ctrl[11:9]=0; with DECODE_ILLEGAL_TRAP_EN, in_ins=0xFFFFFFFF -> out_illegal=1.
